// File: rtl/dlx_fetch.sv
// dlx_fetch: DLX instruction-fetch stage. Owns the PC, runs the instruction-memory read
// handshake and strobes ID once per fetched word. Define DLX_FETCH_ALIGN_CHECK_EN for misaligned-redirect faults.
module dlx_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] i_address,
  output logic              i_read_req,
  input  logic              i_ready,
  input  logic [31:0]       i_data_in,
  output logic [31:0]       i_data_read,
  output logic              ID,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  input  logic              next_ok,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_fault,
  output logic [2:0]        state
);

  // Handshake: i_read_req rises with i_address already stable and both hold until an edge
  // where i_ready is high; that edge completes the read. If i_read_req is still high in the
  // following cycle, that is a new request (possibly to a new address).
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_DEC   = 3'd2,
    S_WAIT  = 3'd3,
    S_FLUSH = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t            st;
  logic [ADDR_W-1:0] fetch_pc;
  logic              pending;
  logic              pending_mis;
  logic [ADDR_W-3:0] pending_hi;
  logic              have_tgt;
  logic              red_mis;
  logic              tgt_mis;
  logic              go;
  logic [ADDR_W-1:0] tgt_al;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] go_addr;

  assign state    = st;
  assign pc_plus4 = pc + ADDR_W'(4);
  assign have_tgt = redirect | pending;
  // A live redirect always beats a pending one (newest target wins).
  assign tgt_al   = redirect ? {redirect_pc[ADDR_W-1:2], 2'b00} : {pending_hi, 2'b00};

`ifdef DLX_FETCH_ALIGN_CHECK_EN
  assign red_mis = |redirect_pc[1:0];
`else
  logic unused_low;
  assign red_mis    = 1'b0;
  assign unused_low = ^redirect_pc[1:0];
`endif

  assign tgt_mis = redirect ? red_mis : (pending & pending_mis);
  assign go_addr = have_tgt ? tgt_al : ((st == S_WAIT && next_ok) ? pc_plus4 : fetch_pc);
  assign go      = !stall && !tgt_mis && (have_tgt || next_ok || st == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_IDLE;
      i_read_req  <= 1'b0;
      i_address   <= RESET_PC;
      i_data_read <= '0;
      ID          <= 1'b0;
      pc          <= RESET_PC;
      npc         <= RESET_PC + ADDR_W'(4);
      fetch_fault <= 1'b0;
      fetch_pc    <= RESET_PC;
      pending     <= 1'b0;
      pending_mis <= 1'b0;
      pending_hi  <= '0;
    end else begin
      ID <= 1'b0;
      case (st)
        S_IDLE, S_WAIT: begin
          if (tgt_mis) begin
            st          <= S_FAULT;
            fetch_fault <= 1'b1;
            pending     <= 1'b0;
          end else if (go) begin
            st         <= S_REQ;
            i_read_req <= 1'b1;
            i_address  <= go_addr;
            fetch_pc   <= go_addr;
            pending    <= 1'b0;
          end else begin
            // Stalled: remember the target so it survives until stall drops.
            if (have_tgt) begin
              pending     <= 1'b1;
              pending_hi  <= go_addr[ADDR_W-1:2];
              pending_mis <= 1'b0;
            end
            if (have_tgt || (st == S_WAIT && next_ok)) fetch_pc <= go_addr;
          end
        end
        S_REQ: begin
          if (i_ready && redirect) begin
            if (tgt_mis) begin
              st          <= S_FAULT;
              fetch_fault <= 1'b1;
              i_read_req  <= 1'b0;
            end else begin
              i_address <= tgt_al;
              fetch_pc  <= tgt_al;
            end
          end else if (i_ready) begin
            st          <= S_DEC;
            ID          <= 1'b1;
            i_read_req  <= 1'b0;
            i_data_read <= i_data_in;
            pc          <= fetch_pc;
            npc         <= fetch_pc + ADDR_W'(4);
          end else if (redirect) begin
            st          <= S_FLUSH;
            pending     <= 1'b1;
            pending_hi  <= tgt_al[ADDR_W-1:2];
            pending_mis <= red_mis;
          end
        end
        S_DEC: begin
          st <= S_WAIT;
          if (redirect) begin
            pending     <= 1'b1;
            pending_hi  <= tgt_al[ADDR_W-1:2];
            pending_mis <= red_mis;
          end
        end
        S_FLUSH: begin
          // The stale read must complete before the target can be requested.
          if (i_ready) begin
            pending <= 1'b0;
            if (tgt_mis) begin
              st          <= S_FAULT;
              fetch_fault <= 1'b1;
              i_read_req  <= 1'b0;
            end else begin
              st        <= S_REQ;
              i_address <= tgt_al;
              fetch_pc  <= tgt_al;
            end
          end else if (redirect) begin
            pending_hi  <= tgt_al[ADDR_W-1:2];
            pending_mis <= red_mis;
          end
        end
        S_FAULT: begin
          i_read_req <= 1'b0;
        end
        default: begin
          st         <= S_IDLE;
          i_read_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_fetch.sv
// tb_dlx_fetch: directed bench for dlx_fetch with a latency-programmable memory responder
// and expected-queue scoreboards for issued requests and decoded words.
module tb_dlx_fetch;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic        clk;
  logic        reset_n;
  logic [31:0] i_address;
  logic        i_read_req;
  logic        i_ready;
  logic [31:0] i_data_in;
  logic [31:0] i_data_read;
  logic        ID;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        next_ok;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int id_count = 0;
  int exp_id_count = 0;
  int lat = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_req_q[$];
  logic [31:0] exp_dec_q[$];

  dlx_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_address(i_address), .i_read_req(i_read_req), .i_ready(i_ready), .i_data_in(i_data_in),
    .i_data_read(i_data_read), .ID(ID), .pc(pc), .npc(npc),
    .next_ok(next_ok), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2001_1000 + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (state !== s && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_req_q.push_back(a);
    exp_dec_q.push_back(a);
    exp_id_count++;
    exp_pc = a;
  endtask

  task automatic expect_req_only(input logic [31:0] a);
    exp_req_q.push_back(a);
  endtask

  task automatic next_word();
    wait_state(S_WAIT, "seq_wait");
    next_ok = 1'b1;
    expect_fetch(exp_pc + 32'd4);
    tick(1);
    next_ok = 1'b0;
  endtask

  // memory responder: i_ready after lat wait cycles per request
  initial begin
    int cnt;
    cnt = 0;
    i_ready = 1'b0;
    i_data_in = '0;
    forever begin
      @(negedge clk);
      if (!reset_n || !i_read_req) begin
        i_ready = 1'b0;
        cnt = 0;
      end else if (cnt >= lat) begin
        i_ready = 1'b1;
        i_data_in = mem_word(i_address);
        cnt = 0;
      end else begin
        i_ready = 1'b0;
        cnt++;
      end
    end
  end

  // scoreboard: new requests and decode strobes, sampled just after the rising edge
  initial begin
    logic last_req;
    logic last_id;
    logic [31:0] e;
    last_req = 1'b0;
    last_id = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && i_read_req && (!last_req || i_ready)) begin
        chk("req_align", {30'd0, i_address[1:0]}, 32'd0);
        chk("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
        if (exp_req_q.size() != 0) begin
          e = exp_req_q.pop_front();
          chk("req_addr", i_address, e);
        end
      end
      if (reset_n && ID) begin
        id_count++;
        chk("id_width", 32'(last_id), 32'd0);
        chk("dec_expected", 32'(exp_dec_q.size() != 0), 32'd1);
        if (exp_dec_q.size() != 0) begin
          e = exp_dec_q.pop_front();
          chk("dec_pc", pc, e);
          chk("dec_npc", npc, e + 32'd4);
          chk("dec_data", i_data_read, mem_word(e));
        end
      end
      last_req = reset_n ? i_read_req : 1'b0;
      last_id = reset_n ? ID : 1'b0;
    end
  end

  initial begin
    reset_n = 1'b0;
    next_ok = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    tick(2);
    chk("rst_req", 32'(i_read_req), 32'd0);
    chk("rst_addr", i_address, 32'h0);
    chk("rst_data", i_data_read, 32'h0);
    chk("rst_id", 32'(ID), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_npc", npc, 32'h4);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_state", 32'(state), 32'(S_IDLE));

    // T1: first fetch, zero wait states, ID in cycle 3
    expect_fetch(32'h0);
    reset_n = 1'b1;
    tick(2);
    chk("t1_id_cycle3", 32'(ID), 32'd1);
    chk("t1_pc", pc, 32'h0);
    chk("t1_npc", npc, 32'h4);

    // T2: sequential fetches, then stall holds in WAIT
    for (int k = 0; k < 3; k++) next_word();
    wait_state(S_WAIT, "t2_wait");
    stall = 1'b1;
    next_ok = 1'b1;
    repeat (4) begin
      tick(1);
      chk("t2_stall_state", 32'(state), 32'(S_WAIT));
      chk("t2_stall_req", 32'(i_read_req), 32'd0);
    end
    stall = 1'b0;
    expect_fetch(exp_pc + 32'd4);
    tick(1);
    next_ok = 1'b0;
    chk("t2_release", 32'(state), 32'(S_REQ));

    // T3: redirect while a slow read is in flight
    wait_state(S_WAIT, "t3_wait");
    lat = 3;
    next_ok = 1'b1;
    expect_req_only(exp_pc + 32'd4);
    tick(1);
    next_ok = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    expect_fetch(32'h100);
    tick(1);
    redirect = 1'b0;
    chk("t3_flush_state", 32'(state), 32'(S_FLUSH));
    chk("t3_flush_req", 32'(i_read_req), 32'd1);
    wait_state(S_WAIT, "t3_done");
    lat = 0;

    // redirect on the same edge as i_ready
    next_ok = 1'b1;
    expect_req_only(exp_pc + 32'd4);
    tick(1);
    next_ok = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    expect_fetch(32'h200);
    tick(1);
    redirect = 1'b0;
    chk("same_edge_state", 32'(state), 32'(S_REQ));
    chk("same_edge_addr", i_address, 32'h200);
    chk("same_edge_noid", 32'(ID), 32'd0);

    // T4: redirect and next_ok together, redirect wins
    wait_state(S_WAIT, "t4_wait");
    next_ok = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    expect_fetch(32'h40);
    tick(1);
    next_ok = 1'b0;
    redirect = 1'b0;
    chk("t4_addr", i_address, 32'h40);

    // redirect during DEC is applied from WAIT
    wait_state(S_DEC, "dec_wait");
    redirect = 1'b1;
    redirect_pc = 32'h80;
    expect_fetch(32'h80);
    tick(1);
    redirect = 1'b0;
    chk("dec_redir_wait", 32'(state), 32'(S_WAIT));
    tick(1);
    chk("dec_redir_state", 32'(state), 32'(S_REQ));
    chk("dec_redir_addr", i_address, 32'h80);

    // second redirect while pending overwrites the target
    wait_state(S_WAIT, "ovw_wait");
    lat = 3;
    next_ok = 1'b1;
    expect_req_only(exp_pc + 32'd4);
    tick(1);
    next_ok = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h300;
    tick(1);
    redirect_pc = 32'h340;
    expect_fetch(32'h340);
    tick(1);
    redirect = 1'b0;
    wait_state(S_WAIT, "ovw_done");
    lat = 0;

    // T5: wrap at the top of the address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    expect_fetch(32'hFFFF_FFFC);
    tick(1);
    redirect = 1'b0;
    wait_state(S_WAIT, "t5_wait");
    chk("t5_pc", pc, 32'hFFFF_FFFC);
    chk("t5_npc", npc, 32'h0);
    next_ok = 1'b1;
    expect_fetch(32'h0);
    tick(1);
    next_ok = 1'b0;
    chk("t5_wrap_addr", i_address, 32'h0);

    // reset in the middle of a read drops the request at once
    wait_state(S_WAIT, "rst_mid_wait");
    lat = 3;
    next_ok = 1'b1;
    expect_req_only(exp_pc + 32'd4);
    tick(1);
    next_ok = 1'b0;
    tick(1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(i_read_req), 32'd0);
    chk("rst_mid_state", 32'(state), 32'(S_IDLE));
    chk("rst_mid_addr", i_address, 32'h0);
    tick(2);
    expect_fetch(32'h0);
    reset_n = 1'b1;
    wait_state(S_WAIT, "rst_mid_done");
    lat = 0;

    // T6: misaligned redirect target
    redirect = 1'b1;
    redirect_pc = 32'h102;
`ifdef DLX_FETCH_ALIGN_CHECK_EN
    tick(1);
    redirect = 1'b0;
    chk("t6_state", 32'(state), 32'(S_FAULT));
    chk("t6_fault", 32'(fetch_fault), 32'd1);
    next_ok = 1'b1;
    repeat (6) begin
      tick(1);
      chk("t6_no_req", 32'(i_read_req), 32'd0);
      chk("t6_sticky", 32'(fetch_fault), 32'd1);
    end
    next_ok = 1'b0;
`else
    expect_fetch(32'h100);
    tick(1);
    redirect = 1'b0;
    chk("t6_addr", i_address, 32'h100);
    chk("t6_fault", 32'(fetch_fault), 32'd0);
    wait_state(S_WAIT, "t6_done");
`endif

    // final report
    tick(3);
    chk("req_q_empty", 32'(exp_req_q.size()), 32'd0);
    chk("dec_q_empty", 32'(exp_dec_q.size()), 32'd0);
    chk("id_count", 32'(id_count), 32'(exp_id_count));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
